// File: rtl/osiris_pipe_pkg.sv
// Shared types and encodings for the Osiris I pipeline stage boundaries.
package osiris_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam int CTRL_WIDTH_DEF = 4;

    // result_src field encodings carried in the control payload
    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline register with flush (control squash), optional 2-entry skid buffer
// and a saturating downstream-stall counter.
module pipe_stage_hs
    import osiris_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
    parameter bit SKID       = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    pipe_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q;
    logic                  valid;
    logic                  in_acc;
    logic                  out_acc;

    assign valid   = (state_q != ST_EMPTY);
    assign in_acc  = i_valid && o_ready;
    assign out_acc = valid && i_ready;

    generate
        if (SKID) begin : g_skid
            logic [DATA_WIDTH-1:0] skid_data_d;
            logic [CTRL_WIDTH-1:0] skid_ctrl_d;

            // Ready depends only on state, so the upstream path sees a flop output.
            assign o_ready = !rst && (state_q != ST_SKID);

            always_comb begin
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                if (i_flush) begin
                    skid_ctrl_d = '0;
                end else if ((state_q == ST_FULL) && in_acc && !out_acc) begin
                    skid_data_d = i_data;
                    skid_ctrl_d = i_ctrl;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end
        end else begin : g_single
            assign o_ready     = !rst && (!valid || i_ready);
            assign skid_data_q = '0;
            assign skid_ctrl_q = '0;
        end
    endgenerate

    // Flush wins over any handshake; data is left in place, only control is squashed.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (i_flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_acc) begin
                        state_d     = ST_FULL;
                        main_data_d = i_data;
                        main_ctrl_d = i_ctrl;
                    end
                end
                ST_FULL: begin
                    if (in_acc && out_acc) begin
                        main_data_d = i_data;
                        main_ctrl_d = i_ctrl;
                    end else if (in_acc) begin
                        state_d = ST_SKID;
                    end else if (out_acc) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_acc) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    assign o_valid = valid;
    assign o_data  = main_data_q;
    assign o_ctrl  = valid ? main_ctrl_q : '0;

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid && !i_ready),
        .count (o_stall_cnt)
    );

endmodule
